// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch stage with a DEPTH-entry fetch queue.
// Holds the word PC, drives imem_addr, pushes {pc, instr} into a FIFO toward
// decode and reloads the PC on a redirect (jumpR > jump > taken branch).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_addr / imem_rdata  instruction memory word address / combinational data
//   if_valid/if_ready       head handshake toward decode
//   if_pc, if_instr         head entry fields
//   redir_pc, branch, zero, jump, jumpR, imm16, tInstr, jumprAddr
//                           redirect request from a later stage
//   q_count                 occupied queue entries
module fetch_queue_unit #(
    parameter int unsigned   AW       = 30,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned   IMM_W    = 16,
    parameter int unsigned   TGT_W    = 26,
    parameter int unsigned   DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [AW-1:0]            imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [AW-1:0]            if_pc,
    output logic [31:0]              if_instr,
    input  logic [AW-1:0]            redir_pc,
    input  logic                     branch,
    input  logic                     zero,
    input  logic                     jump,
    input  logic                     jumpR,
    input  logic [IMM_W-1:0]         imm16,
    input  logic [TGT_W-1:0]         tInstr,
    input  logic [AW-1:0]            jumprAddr,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [AW-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    logic [AW-1:0]    pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic             redirect_c, full_c, pop_c, push_c;
    logic [AW-1:0]    target_c;

    // Redirect target; later assignments win, giving jumpR the highest priority.
    always_comb begin
        target_c = redir_pc + AW'(1) + {{(AW-IMM_W){imm16[IMM_W-1]}}, imm16};
        if (jump) begin
            target_c = {redir_pc[AW-1:TGT_W], tInstr};
        end
        if (jumpR) begin
            target_c = jumprAddr;
        end
    end

    // Handshake: a redirect suppresses both push and pop in its cycle.
    always_comb begin
        redirect_c = jumpR | jump | (branch & ~zero);
        full_c     = (cnt_q == CNT_W'(DEPTH));
        pop_c      = valid_q & if_ready & ~redirect_c;
        push_c     = ~redirect_c & (~full_c | pop_c);
    end

    // Next-state for PC, pointers and occupancy.
    always_comb begin
        pc_d  = pc_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (redirect_c) begin
            pc_d  = target_c;
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop_c) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (push_c) begin
                wr_d = wr_q + PTR_W'(1);
                pc_d = pc_q + AW'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
        valid_d = (cnt_d != '0);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Queue storage; stale contents are harmless since pointers reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem[wr_q]    <= pc_q;
            instr_mem[wr_q] <= imem_rdata;
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_pc     = pc_mem[rd_q];
    assign if_instr  = instr_mem[rd_q];
    assign q_count   = cnt_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_fetch_queue_unit;

    localparam int unsigned   AW    = 30;
    localparam int unsigned   IMM_W = 16;
    localparam int unsigned   TGT_W = 26;
    localparam int unsigned   DEPTH = 2;
    localparam logic [AW-1:0] RST   = 30'h100;

    logic             clk = 1'b0;
    logic             reset;
    logic [AW-1:0]    imem_addr;
    logic [31:0]      imem_rdata;
    logic             if_valid;
    logic             if_ready;
    logic [AW-1:0]    if_pc;
    logic [31:0]      if_instr;
    logic [AW-1:0]    redir_pc;
    logic             branch, zero, jump, jumpR;
    logic [IMM_W-1:0] imm16;
    logic [TGT_W-1:0] tInstr;
    logic [AW-1:0]    jumprAddr;
    logic [$clog2(DEPTH):0] q_count;

    fetch_queue_unit #(
        .AW(AW), .RESET_PC(RST), .IMM_W(IMM_W), .TGT_W(TGT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr),
        .redir_pc(redir_pc), .branch(branch), .zero(zero),
        .jump(jump), .jumpR(jumpR), .imm16(imm16), .tInstr(tInstr),
        .jumprAddr(jumprAddr), .q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] m_pc;
    bit            live = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] m_target();
        logic [AW-1:0] hi_mask;
        if (jumpR) return jumprAddr;
        hi_mask = ~AW'((64'd1 << TGT_W) - 64'd1);
        if (jump) return (redir_pc & hi_mask) | AW'(tInstr);
        return redir_pc + AW'(1) + AW'($signed(imm16));
    endfunction

    // Behavioural model: evaluated with the inputs present at the clock edge.
    task automatic model_update();
        bit redirect, do_pop, do_push;
        if (reset) begin
            m_pc = RST;
            mq.delete();
            return;
        end
        redirect = jumpR || jump || (branch && !zero);
        if (redirect) begin
            m_pc = m_target();
            mq.delete();
            return;
        end
        do_pop  = (mq.size() != 0) && if_ready;
        do_push = (mq.size() < DEPTH) || do_pop;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
            m_pc = m_pc + AW'(1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clr_redir();
        branch = 0; zero = 0; jump = 0; jumpR = 0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("imem_addr", 64'(imem_addr), 64'(m_pc));
            chk("q_count", 64'(q_count), 64'(mq.size()));
            chk("if_valid", 64'(if_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("if_pc", 64'(if_pc), 64'(mq[0].pc));
                chk("if_instr", 64'(if_instr), 64'(mq[0].instr));
            end
        end
    end

    initial begin
        int r;
        reset = 1; if_ready = 0; redir_pc = '0; imm16 = '0; tInstr = '0; jumprAddr = '0;
        clr_redir();
        cyc();
        live = 1;
        cyc();
        chk("rst_addr", 64'(imem_addr), 64'h100);
        chk("rst_count", 64'(q_count), 64'd0);
        chk("rst_valid", 64'(if_valid), 64'd0);

        // Stream after reset
        reset = 0; if_ready = 1;
        cyc();
        chk("stream_valid", 64'(if_valid), 64'd1);
        chk("stream_pc0", 64'(if_pc), 64'h100);
        chk("stream_instr0", 64'(if_instr), 64'hA000_0100);
        cyc();
        chk("stream_pc1", 64'(if_pc), 64'h101);
        repeat (3) cyc();

        // Backpressure from PC 0x10
        if_ready = 0; jumpR = 1; jumprAddr = 30'h10;
        cyc();
        clr_redir();
        chk("bp_addr0", 64'(imem_addr), 64'h10);
        repeat (5) cyc();
        chk("bp_count", 64'(q_count), 64'd2);
        chk("bp_addr", 64'(imem_addr), 64'h12);
        chk("bp_head", 64'(if_pc), 64'h10);
        if_ready = 1;
        cyc();
        chk("bp_rel_head", 64'(if_pc), 64'h11);
        chk("bp_rel_addr", 64'(imem_addr), 64'h13);
        cyc();
        chk("bp_rel_head2", 64'(if_pc), 64'h12);

        // Branch taken then untaken
        redir_pc = 30'h20; imm16 = 16'hFFFC; branch = 1; zero = 0;
        cyc();
        clr_redir();
        chk("br_taken_addr", 64'(imem_addr), 64'h1D);
        chk("br_taken_flush", 64'(q_count), 64'd0);
        branch = 1; zero = 1;
        cyc();
        clr_redir();
        chk("br_untaken_addr", 64'(imem_addr), 64'h1E);
        chk("br_untaken_count", 64'(q_count), 64'd1);

        // Priority
        jumpR = 1; jump = 1; branch = 1; zero = 0; jumprAddr = 30'h3FF;
        cyc();
        clr_redir();
        chk("prio_jumpr", 64'(imem_addr), 64'h3FF);
        jump = 1; redir_pc = 30'h3C00_0005; tInstr = 26'h123;
        cyc();
        clr_redir();
        chk("prio_jump", 64'(imem_addr), 64'h3C00_0123);

        // Redirect with full queue and if_ready high
        if_ready = 0;
        repeat (3) cyc();
        chk("full_count", 64'(q_count), 64'd2);
        if_ready = 1; jumpR = 1; jumprAddr = 30'h200;
        cyc();
        clr_redir();
        chk("rdf_count", 64'(q_count), 64'd0);
        chk("rdf_addr", 64'(imem_addr), 64'h200);
        cyc();
        chk("rdf_head", 64'(if_pc), 64'h200);

        // PC wrap
        jumpR = 1; jumprAddr = 30'h3FFF_FFFF;
        cyc();
        clr_redir();
        chk("wrap_pre", 64'(imem_addr), 64'h3FFF_FFFF);
        cyc();
        chk("wrap_addr", 64'(imem_addr), 64'h0);
        chk("wrap_head", 64'(if_pc), 64'h3FFF_FFFF);

        // Reset with redirect and full queue
        if_ready = 0;
        repeat (3) cyc();
        reset = 1; jumpR = 1; jumprAddr = 30'h55; if_ready = 1;
        cyc();
        reset = 0; clr_redir();
        chk("rstmid_addr", 64'(imem_addr), 64'h100);
        chk("rstmid_count", 64'(q_count), 64'd0);
        chk("rstmid_valid", 64'(if_valid), 64'd0);

        // Randomized traffic
        repeat (3000) begin
            if_ready  = ($urandom_range(0, 9) < 7);
            r         = $urandom_range(0, 99);
            branch    = (r < 5) || (r == 9);
            zero      = $urandom_range(0, 1) == 1;
            jump      = (r == 5) || (r == 6) || (r == 9);
            jumpR     = (r == 7) || (r == 9);
            reset     = (r == 99);
            redir_pc  = AW'($urandom);
            imm16     = IMM_W'($urandom);
            tInstr    = TGT_W'($urandom);
            jumprAddr = (r == 7 && $urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : AW'($urandom);
            cyc();
        end
        reset = 0; clr_redir();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
